// File: rtl/pingpong_accum_buffer_if.sv
// Bus bundle for the ping-pong accumulator buffer: MAC write side, drain stream and debug taps.
// out_vld/out_rdy: a beat transfers on a rising clk edge where both are high; once out_vld is high, out_data/out_last hold until that transfer.
interface pingpong_accum_buffer_if #(
   parameter int NUM_CH      = 8,
   parameter int IN_W        = 33,
   parameter int ACC_W       = 28,
   parameter int OUT_W       = 17,
   parameter int DRAIN_LANES = 2
);
   logic                          init_vld;
   logic signed [ACC_W-1:0]       bias_i;
   logic                          res_vld;
   logic [NUM_CH*IN_W-1:0]        res;
   logic                          acc_en;
   logic                          swap;
   logic                          drain_start;
   logic                          relu_en;
   logic                          out_vld;
   logic                          out_rdy;
   logic [DRAIN_LANES*OUT_W-1:0]  out_data;
   logic                          out_last;
   logic                          busy;
   logic                          sat_flag;
   logic                          state_dbg;
   logic                          wr_bank_dbg;

   modport master (
      output init_vld, bias_i, res_vld, res, acc_en, swap, drain_start, relu_en, out_rdy,
      input  out_vld, out_data, out_last, busy, sat_flag, state_dbg, wr_bank_dbg
   );

   modport slave (
      input  init_vld, bias_i, res_vld, res, acc_en, swap, drain_start, relu_en, out_rdy,
      output out_vld, out_data, out_last, busy, sat_flag, state_dbg, wr_bank_dbg
   );
endinterface

// File: rtl/pingpong_accum_buffer.sv
// Two-bank MAC accumulator: one bank takes saturating writes while the other drains
// as rounded, saturated, optionally ReLU'd words over a valid/ready stream.
module pingpong_accum_buffer #(
   parameter int NUM_CH      = 8,
   parameter int IN_W        = 33,
   parameter int ACC_W       = 28,
   parameter int OUT_W       = 17,
   parameter int FRAC_SHIFT  = 11,
   parameter int DRAIN_LANES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pingpong_accum_buffer_if.slave bus
);
   localparam int BEATS = NUM_CH / DRAIN_LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   HALF    = (ACC_W+1)'(1) << (FRAC_SHIFT-1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                       state;
   logic                         wr_bank;
   logic                         rd_bank;
   logic                         swap_pend;
   logic                         relu_q;
   logic [BW-1:0]                beat;
   logic                         out_vld_q;
   logic                         out_last_q;
   logic                         busy_q;
   logic                         sat_q;
   logic [DRAIN_LANES*OUT_W-1:0] out_data_q;

   logic signed [ACC_W-1:0] bank [2][NUM_CH];

   // Write path: cast each MAC lane to ACC_W, then optionally add with a second clamp.
   logic signed [ACC_W-1:0] wr_val [NUM_CH];
   logic [NUM_CH-1:0]       wr_clamp;
   logic signed [IN_W-1:0]  res_k;
   logic signed [ACC_W-1:0] res_sat;
   logic                    res_clamp;
   logic signed [ACC_W:0]   sum;

   always_comb begin
      res_k     = '0;
      res_sat   = '0;
      res_clamp = 1'b0;
      sum       = '0;
      wr_clamp  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         wr_val[k] = '0;
         res_k     = bus.res[k*IN_W +: IN_W];
         res_clamp = (res_k[IN_W-1:ACC_W-1] != {(IN_W-ACC_W+1){res_k[IN_W-1]}});
         res_sat   = res_clamp ? (res_k[IN_W-1] ? ACC_MIN : ACC_MAX) : res_k[ACC_W-1:0];
         sum       = {bank[wr_bank][k][ACC_W-1], bank[wr_bank][k]} + {res_sat[ACC_W-1], res_sat};
         if (bus.acc_en && (sum[ACC_W] != sum[ACC_W-1])) begin
            wr_val[k]   = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            wr_clamp[k] = 1'b1;
         end else if (bus.acc_en) begin
            wr_val[k]   = sum[ACC_W-1:0];
            wr_clamp[k] = res_clamp;
         end else begin
            wr_val[k]   = res_sat;
            wr_clamp[k] = res_clamp;
         end
      end
   end

   // Drain path: builds the beat that will be registered next (first beat or the following one).
   logic                         nxt_sel;
   logic [BW-1:0]                nxt_beat;
   logic                         nxt_relu;
   logic [IW-1:0]                idx;
   logic signed [ACC_W-1:0]      acc_w;
   logic signed [ACC_W:0]        rnd;
   logic signed [ACC_W:0]        shf;
   logic signed [OUT_W-1:0]      word;
   logic [DRAIN_LANES*OUT_W-1:0] nxt_data;
   logic                         nxt_clamp;
   logic                         load_beat;

   always_comb begin
      nxt_sel   = rd_bank;
      nxt_beat  = beat + 1'b1;
      nxt_relu  = relu_q;
      if (state == IDLE) begin
         nxt_sel  = bus.swap ? wr_bank : ~wr_bank;
         nxt_beat = '0;
         nxt_relu = bus.relu_en;
      end
      idx       = '0;
      acc_w     = '0;
      rnd       = '0;
      shf       = '0;
      word      = '0;
      nxt_data  = '0;
      nxt_clamp = 1'b0;
      for (int j = 0; j < DRAIN_LANES; j++) begin
         idx   = (int'(nxt_beat) < BEATS) ? IW'(int'(nxt_beat) * DRAIN_LANES + j) : IW'(j);
         acc_w = bank[nxt_sel][idx];
         rnd   = {acc_w[ACC_W-1], acc_w} + HALF;
         shf   = rnd >>> FRAC_SHIFT;
         if (shf[ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){shf[ACC_W]}}) begin
            word      = shf[ACC_W] ? OUT_MIN : OUT_MAX;
            nxt_clamp = 1'b1;
         end else begin
            word = shf[OUT_W-1:0];
         end
         if (nxt_relu && word[OUT_W-1]) word = '0;
         nxt_data[j*OUT_W +: OUT_W] = word;
      end
   end

   assign load_beat = ((state == IDLE) && bus.drain_start) ||
                      ((state == DRAIN) && out_vld_q && bus.out_rdy && !out_last_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b1;
         swap_pend  <= 1'b0;
         relu_q     <= 1'b0;
         beat       <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
         busy_q     <= 1'b0;
         sat_q      <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < NUM_CH; k++)
               bank[b][k] <= '0;
      end else begin
         if (bus.init_vld) begin
            for (int k = 0; k < NUM_CH; k++) bank[wr_bank][k] <= bus.bias_i;
         end else if (bus.res_vld) begin
            for (int k = 0; k < NUM_CH; k++) bank[wr_bank][k] <= wr_val[k];
         end
         if ((!bus.init_vld && bus.res_vld && (|wr_clamp)) || (load_beat && nxt_clamp))
            sat_q <= 1'b1;

         case (state)
            IDLE: begin
               if (bus.swap) wr_bank <= ~wr_bank;
               if (bus.drain_start) begin
                  state      <= DRAIN;
                  busy_q     <= 1'b1;
                  out_vld_q  <= 1'b1;
                  out_data_q <= nxt_data;
                  out_last_q <= (BEATS == 1);
                  beat       <= '0;
                  rd_bank    <= nxt_sel;
                  relu_q     <= bus.relu_en;
               end
            end
            DRAIN: begin
               if (bus.swap) swap_pend <= 1'b1;
               if (out_vld_q && bus.out_rdy) begin
                  if (out_last_q) begin
                     state      <= IDLE;
                     busy_q     <= 1'b0;
                     out_vld_q  <= 1'b0;
                     out_last_q <= 1'b0;
                     swap_pend  <= 1'b0;
                     if (swap_pend || bus.swap) wr_bank <= ~wr_bank;
                  end else begin
                     beat       <= nxt_beat;
                     out_data_q <= nxt_data;
                     out_last_q <= (nxt_beat == BW'(BEATS-1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_vld     = out_vld_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_last    = out_last_q;
   assign bus.busy        = busy_q;
   assign bus.sat_flag    = sat_q;
   assign bus.state_dbg   = state;
   assign bus.wr_bank_dbg = wr_bank;
endmodule

// File: tb/tb_pingpong_accum_buffer.sv
// Directed bench for pingpong_accum_buffer: accumulate, rounding, saturation,
// backpressure, ping-pong under load and reset mid-drain, with hand-computed expectations.
module tb_pingpong_accum_buffer;
  localparam int NUM_CH = 8;
  localparam int IN_W = 33;
  localparam int OUT_W = 17;
  localparam int DRAIN_LANES = 2;
  localparam int BEATS = NUM_CH / DRAIN_LANES;

  logic clk;
  logic rst_n;
  int vec_cnt;
  int miss_cnt;
  logic wb;
  logic [OUT_W-1:0] exp_q[$];

  pingpong_accum_buffer_if bus ();

  pingpong_accum_buffer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_init(input int val);
    bus.init_vld = 1'b1;
    bus.bias_i = 28'(val);
    tick();
    bus.init_vld = 1'b0;
  endtask

  task automatic set_res(input int v[NUM_CH]);
    for (int k = 0; k < NUM_CH; k++) bus.res[k*IN_W +: IN_W] = 33'(v[k]);
  endtask

  task automatic do_res(input bit acc, input int v[NUM_CH]);
    set_res(v);
    bus.acc_en = acc;
    bus.res_vld = 1'b1;
    tick();
    bus.res_vld = 1'b0;
  endtask

  task automatic do_swap();
    bus.swap = 1'b1;
    wb = ~wb;
    tick();
    bus.swap = 1'b0;
  endtask

  task automatic push8(input int v[NUM_CH]);
    for (int k = 0; k < NUM_CH; k++) exp_q.push_back(OUT_W'(v[k]));
  endtask

  // scoreboard-driven drain: every accepted lane is popped from exp_q
  task automatic drain(input bit relu, input bit sw_start, input int stall_beat, input bit sw_mid);
    int beats;
    int cyc;
    int stall;
    beats = 0;
    cyc = 0;
    stall = 0;
    bus.drain_start = 1'b1;
    bus.relu_en = relu;
    bus.swap = sw_start;
    if (sw_start) wb = ~wb;
    tick();
    bus.drain_start = 1'b0;
    bus.relu_en = 1'b0;
    bus.swap = 1'b0;
    chk("busy_start", bus.busy, 1);
    chk("wr_bank_start", bus.wr_bank_dbg, wb);
    while (beats < BEATS && cyc < 40) begin
      bus.swap = sw_mid && (beats == 1 || beats == 2);
      bus.drain_start = sw_mid && (beats == 2);
      if (beats == stall_beat && stall < 3) begin
        bus.out_rdy = 1'b0;
        chk("hold_vld", bus.out_vld, 1);
        chk("hold_last", bus.out_last, beats == BEATS - 1);
        for (int j = 0; j < DRAIN_LANES; j++)
          chk("hold_word", bus.out_data[j*OUT_W +: OUT_W], exp_q[j]);
        stall++;
      end else begin
        bus.out_rdy = 1'b1;
        chk("out_vld", bus.out_vld, 1);
        chk("busy", bus.busy, 1);
        chk("out_last", bus.out_last, beats == BEATS - 1);
        for (int j = 0; j < DRAIN_LANES; j++)
          chk("word", bus.out_data[j*OUT_W +: OUT_W], exp_q.pop_front());
        beats++;
      end
      tick();
      cyc++;
      if (beats < BEATS) chk("wr_bank_hold", bus.wr_bank_dbg, wb);
    end
    bus.swap = 1'b0;
    bus.drain_start = 1'b0;
    bus.out_rdy = 1'b1;
    if (sw_mid) wb = ~wb;
    chk("handshakes", beats, BEATS);
    chk("vld_drop", bus.out_vld, 0);
    chk("busy_drop", bus.busy, 0);
    chk("last_drop", bus.out_last, 0);
    chk("wr_bank_end", bus.wr_bank_dbg, wb);
  endtask

  initial begin
    vec_cnt = 0;
    miss_cnt = 0;
    wb = 1'b0;
    rst_n = 1'b0;
    bus.init_vld = 1'b0;
    bus.bias_i = '0;
    bus.res_vld = 1'b0;
    bus.res = '0;
    bus.acc_en = 1'b0;
    bus.swap = 1'b0;
    bus.drain_start = 1'b0;
    bus.relu_en = 1'b0;
    bus.out_rdy = 1'b1;
    tick();
    tick();
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_wr_bank", bus.wr_bank_dbg, 0);
    chk("rst_state", bus.state_dbg, 0);
    rst_n = 1'b1;
    tick();

    // accumulate: 100 + 50 + 50 in bank0
    do_init(100);
    do_res(1'b1, '{50, 50, 50, 50, 50, 50, 50, 50});
    do_res(1'b1, '{50, 50, 50, 50, 50, 50, 50, 50});
    for (int k = 0; k < NUM_CH; k++) chk("acc_lane", dut.bank[0][k], 200);
    push8('{0, 0, 0, 0, 0, 0, 0, 0});
    drain(1'b0, 1'b1, -1, 1'b0);
    chk("acc_sat", bus.sat_flag, 0);

    // rounding into bank1, then a ReLU re-drain of the same bank
    do_res(1'b0, '{3072, -3072, 1023, 1024, -1025, -1024, 0, 0});
    push8('{2, -1, 0, 1, -1, 0, 0, 0});
    drain(1'b0, 1'b1, -1, 1'b0);
    push8('{2, 0, 0, 1, 0, 0, 0, 0});
    drain(1'b1, 1'b0, -1, 1'b0);
    chk("round_sat", bus.sat_flag, 0);

    // saturation on cast and on accumulate into bank0
    do_res(1'b0, '{1073741824, -1073741824, 134217000, -134217000, 0, 0, 0, 0});
    chk("cast_sat", bus.sat_flag, 1);
    do_res(1'b1, '{0, 0, 1000, -1000, 0, 0, 0, 0});
    chk("sat_l0", dut.bank[0][0], 134217727);
    chk("sat_l1", dut.bank[0][1], -134217728);
    chk("sat_l2", dut.bank[0][2], 134217727);
    chk("sat_l3", dut.bank[0][3], -134217728);
    push8('{65535, -65536, 65535, -65536, 0, 0, 0, 0});
    drain(1'b0, 1'b1, -1, 1'b0);

    // backpressure: stall three cycles at beat 1
    do_res(1'b0, '{2048, 4096, 6144, 8192, 10240, 12288, 14336, 16384});
    push8('{1, 2, 3, 4, 5, 6, 7, 8});
    drain(1'b0, 1'b1, 1, 1'b0);

    // ping-pong: drain bank0 while bank1 accumulates every cycle; swaps mid-drain
    do_res(1'b0, '{-2048, -4096, -6144, -8192, -10240, -12288, -14336, -16384});
    do_swap();
    chk("pp_wr_bank", bus.wr_bank_dbg, 1);
    set_res('{3, 3, 3, 3, 3, 3, 3, 3});
    bus.acc_en = 1'b1;
    bus.res_vld = 1'b1;
    push8('{-1, -2, -3, -4, -5, -6, -7, -8});
    drain(1'b0, 1'b0, -1, 1'b1);
    bus.res_vld = 1'b0;
    chk("pp_wr_bank_end", bus.wr_bank_dbg, 0);
    for (int k = 0; k < NUM_CH; k++) chk("pp_bank1", dut.bank[1][k], (k + 1) * 2048 + 15);

    // reset in the middle of a drain
    do_swap();
    chk("rm_wr_bank", bus.wr_bank_dbg, 1);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    bus.out_rdy = 1'b1;
    tick();
    tick();
    chk("rm_vld_beat2", bus.out_vld, 1);
    chk("rm_busy_beat2", bus.busy, 1);
    rst_n = 1'b0;
    wb = 1'b0;
    tick();
    chk("rm_out_vld", bus.out_vld, 0);
    chk("rm_busy", bus.busy, 0);
    chk("rm_sat", bus.sat_flag, 0);
    chk("rm_wr_bank", bus.wr_bank_dbg, 0);
    chk("rm_out_data", bus.out_data, 0);
    chk("rm_bank0", dut.bank[0][0], 0);
    chk("rm_bank1", dut.bank[1][7], 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rm_no_beats", bus.out_vld, 0);
    chk("rm_state", bus.state_dbg, 0);

    // output clamp alone sets sat_flag
    do_res(1'b0, '{134217727, 0, 0, 0, 0, 0, 0, 0});
    chk("oc_no_sat", bus.sat_flag, 0);
    push8('{65535, 0, 0, 0, 0, 0, 0, 0});
    drain(1'b0, 1'b1, -1, 1'b0);
    chk("oc_sat", bus.sat_flag, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
